mine_grid_dp: RTL and testbench

//  Parametrised Minesweeper datapath for a ROWS x COLS board, driven by a single clock.
//  - Places NUM_MINES mines using an internal LFSR; a preset mask may be loaded instead.
//  - Accepts one cell probe at a time and counts the mines among the full 8-cell neighbourhood.
//  - Edge masking is correct at every border; there is no row wrap-around.
//  - Tracks cleared cells, hit, win and a persistent score.
//  - Sits between the game-control FSM (start/load) and the display logic (result outputs).

---
 rtl/mine_grid_dp.sv | 186 ++++++++++++++++++
 tb/tb_mine_grid_dp.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mine_grid_dp.sv
// Minesweeper datapath: mine placement (LFSR or preset mask), one probe at a time,
// 8-neighbour mine count with border masking, win/hit tracking and a persistent score.
module mine_grid_dp #(
    parameter int          ROWS      = 5,
    parameter int          COLS      = 5,
    parameter int          NUM_MINES = 3,
    parameter int          SCORE_W   = 32,
    parameter logic [15:0] SEED      = 16'hACE1,
    localparam int         CELLS     = ROWS * COLS,
    localparam int         IDX_W     = $clog2(CELLS + 1)
) (
    input  logic               clka,
    input  logic               restart_n,
    input  logic               start,
    input  logic               preset,
    input  logic [CELLS-1:0]   mine_mask,
    input  logic               load,
    input  logic [IDX_W-1:0]   data,
    output logic               ready,
    output logic               place_done,
    output logic               result_valid,
    output logic [3:0]         n_nearby,
    output logic               hit,
    output logic               err_invalid,
    output logic               gameover,
    output logic               win,
    output logic [CELLS-1:0]   mines,
    output logic [CELLS-1:0]   cleared,
    output logic [SCORE_W-1:0] global_score,
    output logic [2:0]         state_dbg
);

    // Handshake: a probe is taken on a rising edge where load=1 and ready=1; with ready=0
    // load is ignored. start has priority over load and is honoured in IDLE, READY and DONE.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PLACE  = 3'd1,
        READY  = 3'd2,
        PROBE  = 3'd3,
        RESULT = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [15:0]      SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [IDX_W-1:0] CELLS_I   = IDX_W'(CELLS);
    localparam logic [IDX_W-1:0] NUM_I     = IDX_W'(NUM_MINES);

    state_t             state;
    logic [15:0]        lfsr;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   placed;
    logic [3:0]         nb_q;

    logic [IDX_W-1:0]   cand;
    logic [CELLS-1:0]   cand_oh;
    logic [CELLS-1:0]   idx_oh;
    logic [CELLS-1:0]   cleared_nxt;
    logic               cand_ok;
    logic               probe_hit;
    logic               probe_win;
    logic               start_ok;
    logic [3:0]         nb_sum;
    int                 nb_row;
    int                 nb_col;

    assign state_dbg   = state;
    assign ready       = (state == READY);
    assign cand        = lfsr[IDX_W-1:0];
    assign cand_oh     = CELLS'(1) << cand;
    assign cand_ok     = (cand < CELLS_I) && !(|(mines & cand_oh));
    assign idx_oh      = CELLS'(1) << idx;
    assign cleared_nxt = cleared | idx_oh;
    assign probe_hit   = |(mines & idx_oh);
    assign probe_win   = !probe_hit && (&(cleared_nxt | mines));
    assign start_ok    = start && ((state == IDLE) || (state == READY) || (state == DONE));

    // Row/col of the probed cell, then a sum over the in-board 3x3 window minus the centre.
    always_comb begin
        nb_row = 0;
        nb_col = 0;
        nb_sum = 4'd0;
        for (int i = 0; i < CELLS; i++) begin
            if (idx == IDX_W'(i)) begin
                nb_row = i / COLS;
                nb_col = i % COLS;
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if ((r >= nb_row - 1) && (r <= nb_row + 1) &&
                    (c >= nb_col - 1) && (c <= nb_col + 1) &&
                    !((r == nb_row) && (c == nb_col))) begin
                    nb_sum = nb_sum + {3'b000, mines[IDX_W'(r * COLS + c)]};
                end
            end
        end
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state        <= IDLE;
            lfsr         <= SEED_EFF;
            idx          <= '0;
            placed       <= '0;
            nb_q         <= '0;
            place_done   <= 1'b0;
            result_valid <= 1'b0;
            err_invalid  <= 1'b0;
            n_nearby     <= '0;
            hit          <= 1'b0;
            gameover     <= 1'b0;
            win          <= 1'b0;
            mines        <= '0;
            cleared      <= '0;
            global_score <= '0;
        end else begin
            lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            place_done   <= 1'b0;
            result_valid <= 1'b0;
            err_invalid  <= 1'b0;
            if (start_ok) begin
                mines    <= preset ? mine_mask : '0;
                cleared  <= '0;
                hit      <= 1'b0;
                gameover <= 1'b0;
                win      <= 1'b0;
                n_nearby <= '0;
                placed   <= '0;
                if (preset) begin
                    place_done <= 1'b1;
                    state      <= READY;
                end else begin
                    state <= PLACE;
                end
            end else begin
                case (state)
                    PLACE: begin
                        if (cand_ok) begin
                            mines  <= mines | cand_oh;
                            placed <= placed + 1'b1;
                            if (placed + 1'b1 == NUM_I) begin
                                place_done <= 1'b1;
                                state      <= READY;
                            end
                        end
                    end
                    READY: begin
                        if (load) begin
                            if (data >= CELLS_I) begin
                                err_invalid <= 1'b1;
                            end else begin
                                idx   <= data;
                                state <= PROBE;
                            end
                        end
                    end
                    PROBE: begin
                        nb_q  <= nb_sum;
                        state <= RESULT;
                    end
                    RESULT: begin
                        n_nearby     <= nb_q;
                        hit          <= probe_hit;
                        cleared      <= cleared_nxt;
                        result_valid <= 1'b1;
                        if (probe_win) begin
                            win <= 1'b1;
                            if (global_score != '1) begin
                                global_score <= global_score + 1'b1;
                            end
                        end
                        if (probe_hit || probe_win) begin
                            gameover <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= READY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mine_grid_dp.sv
// Self-checking bench for mine_grid_dp: directed board scenarios plus randomized games
// scored against a row/column reference model of the board.
module tb_mine_grid_dp;

    localparam int ROWS  = 5;
    localparam int COLS  = 5;
    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = 5;
    localparam int EXP_W = 6;

    logic             clka = 1'b0;
    logic             restart_n = 1'b0;
    logic             start = 1'b0;
    logic             preset = 1'b0;
    logic [CELLS-1:0] mine_mask = '0;
    logic             load = 1'b0;
    logic [IDX_W-1:0] data = '0;
    logic             ready, place_done, result_valid, hit, err_invalid, gameover, win;
    logic [3:0]       n_nearby;
    logic [CELLS-1:0] mines, cleared;
    logic [31:0]      global_score;
    logic [2:0]       state_dbg;

    int checks = 0;
    int failures = 0;

    logic [CELLS-1:0] m_mines = '0;
    logic [CELLS-1:0] m_cleared = '0;
    logic             m_over = 1'b0;
    logic             m_win = 1'b0;
    logic [31:0]      m_score = '0;
    logic [EXP_W-1:0] exp_q[$];

    mine_grid_dp #(.ROWS(ROWS), .COLS(COLS), .NUM_MINES(3), .SCORE_W(32), .SEED(16'hACE1)) dut (
        .clka(clka), .restart_n(restart_n), .start(start), .preset(preset),
        .mine_mask(mine_mask), .load(load), .data(data), .ready(ready),
        .place_done(place_done), .result_valid(result_valid), .n_nearby(n_nearby),
        .hit(hit), .err_invalid(err_invalid), .gameover(gameover), .win(win),
        .mines(mines), .cleared(cleared), .global_score(global_score), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_nbr(input int i, input logic [CELLS-1:0] m);
        int r, c, n;
        r = i / COLS;
        c = i % COLS;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr, cc;
                rr = r + dr;
                cc = c + dc;
                if ((dr != 0 || dc != 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
                    if (m[rr * COLS + cc]) n++;
            end
        end
        return n;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_place_done"}, place_done, 0);
        check({tag, "_rv"}, result_valid, 0);
        check({tag, "_nb"}, n_nearby, 0);
        check({tag, "_hit"}, hit, 0);
        check({tag, "_err"}, err_invalid, 0);
        check({tag, "_over"}, gameover, 0);
        check({tag, "_win"}, win, 0);
        check({tag, "_mines"}, mines, 0);
        check({tag, "_cleared"}, cleared, 0);
        check({tag, "_score"}, global_score, 0);
    endtask

    // driver: start a game, then verify the board came back clean
    task automatic do_start(input logic pre, input logic [CELLS-1:0] mask);
        int n;
        @(negedge clka);
        start = 1'b1; preset = pre; mine_mask = mask;
        @(negedge clka);
        start = 1'b0;
        m_cleared = '0; m_over = 1'b0; m_win = 1'b0;
        if (pre) begin
            m_mines = mask;
            check("start_place_done", place_done, 1);
            check("start_mines", mines, mask);
        end else begin
            n = 0;
            while (!place_done && n < 200) begin
                @(negedge clka);
                n++;
            end
            check("lfsr_place_done", place_done, 1);
            check("lfsr_popcount", $countones(mines), 3);
        end
        check("start_ready", ready, 1);
        check("start_cleared", cleared, 0);
        check("start_hit", hit, 0);
        check("start_over", gameover, 0);
        check("start_win", win, 0);
        check("start_nb", n_nearby, 0);
        check("start_score", global_score, m_score);
        @(negedge clka);
        check("place_done_pulse", place_done, 0);
    endtask

    // driver: one probe, expected outcome from the model through the scoreboard queue
    task automatic do_probe(input int i);
        logic [EXP_W-1:0] e;
        logic             h, w;
        @(negedge clka);
        load = 1'b1; data = IDX_W'(i);
        @(negedge clka);
        load = 1'b0;
        if (i >= CELLS) begin
            check("err_pulse", err_invalid, 1);
            check("err_ready", ready, !m_over);
            check("err_cleared", cleared, m_cleared);
            @(negedge clka);
            check("err_drop", err_invalid, 0);
        end else if (m_over) begin
            check("done_ready", ready, 0);
            repeat (3) begin
                @(negedge clka);
                check("done_ignored", result_valid, 0);
            end
            check("done_cleared", cleared, m_cleared);
        end else begin
            h = m_mines[i];
            m_cleared[i] = 1'b1;
            w = !h && ((m_cleared | m_mines) == {CELLS{1'b1}});
            if (w) begin
                m_win = 1'b1;
                if (m_score != 32'hFFFF_FFFF) m_score = m_score + 1;
            end
            if (h || w) m_over = 1'b1;
            exp_q.push_back({w, h, 4'(model_nbr(i, m_mines))});
            check("rv_early1", result_valid, 0);
            @(negedge clka);
            check("rv_early2", result_valid, 0);
            @(negedge clka);
            check("rv_latency", result_valid, 1);
            e = exp_q.pop_front();
            check("nb", n_nearby, e[3:0]);
            check("hit", hit, e[4]);
            check("win", win, e[5]);
            check("cleared", cleared, m_cleared);
            check("over", gameover, m_over);
            check("ready", ready, !m_over);
            check("score", global_score, m_score);
            @(negedge clka);
            check("rv_pulse", result_valid, 0);
        end
    endtask

    logic [CELLS-1:0] mask3;
    logic [CELLS-1:0] rmask;

    initial begin
        mask3 = '0;
        mask3[0] = 1'b1; mask3[6] = 1'b1; mask3[12] = 1'b1;

        // reset
        #2;
        check_all_zero("reset");
        check("reset_state", state_dbg, 0);
        @(negedge clka);
        restart_n = 1'b1;

        // preset board {0,6,12}
        do_start(1'b1, mask3);
        do_probe(1);
        do_probe(24);
        do_probe(6);
        do_probe(3);

        // border masking, no row wrap
        rmask = '0; rmask[4] = 1'b1;
        do_start(1'b1, rmask);
        do_probe(5);
        do_probe(9);
        do_probe(9);

        // full clear of all safe cells gives a win
        do_start(1'b1, mask3);
        for (int i = 0; i < CELLS; i++) if (!mask3[i]) do_probe(i);
        do_probe(2);
        do_start(1'b1, mask3);

        // invalid probe, then start colliding with load
        do_probe(25);
        do_probe(31);
        do_probe(13);
        @(negedge clka);
        start = 1'b1; preset = 1'b1; mine_mask = rmask; load = 1'b1; data = 5'd2;
        @(negedge clka);
        start = 1'b0; load = 1'b0;
        m_mines = rmask; m_cleared = '0; m_over = 1'b0; m_win = 1'b0;
        check("collide_place_done", place_done, 1);
        check("collide_ready", ready, 1);
        check("collide_mines", mines, rmask);
        repeat (3) begin
            @(negedge clka);
            check("collide_no_result", result_valid, 0);
        end
        check("collide_cleared", cleared, 0);

        // LFSR placement games
        for (int g = 0; g < 20; g++) do_start(1'b0, '0);

        // randomized preset games
        for (int g = 0; g < 15; g++) begin
            int k, steps;
            rmask = '0;
            k = $urandom_range(1, 4);
            while ($countones(rmask) < k) rmask[$urandom_range(0, CELLS - 1)] = 1'b1;
            do_start(1'b1, rmask);
            steps = 0;
            while (!m_over && steps < 40) begin
                int sel, p;
                sel = $urandom_range(0, 99);
                if (sel < 5) begin
                    p = $urandom_range(CELLS, 31);
                end else if (sel < 25) begin
                    p = $urandom_range(0, CELLS - 1);
                end else begin
                    p = $urandom_range(0, CELLS - 1);
                    for (int t = 0; t < CELLS; t++) begin
                        if (m_mines[p] || m_cleared[p]) p = (p + 1) % CELLS;
                    end
                end
                do_probe(p);
                steps++;
            end
            do_probe($urandom_range(0, CELLS - 1));
        end

        // asynchronous reset in the middle of a probe
        do_start(1'b1, mask3);
        @(negedge clka);
        load = 1'b1; data = 5'd7;
        @(negedge clka);
        load = 1'b0;
        check("mid_probe_state", state_dbg, 3);
        restart_n = 1'b0;
        #1;
        check_all_zero("abort");
        check("abort_state", state_dbg, 0);
        @(negedge clka);
        restart_n = 1'b1;
        m_score = '0;
        do_start(1'b1, mask3);
        do_probe(18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
